// File: rtl/udp_merger_pkg.sv
// Shared widths and the UDP header layout used by the TX-side merger.
package udp_merger_pkg;

    localparam int IP_ADDR_W       = 32;
    localparam int PKT_TIMESTAMP_W = 64;
    localparam int MAC_INTERFACE_W = 256;
    localparam int MAC_PADBYTES_W  = 5;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;

    localparam int UDP_HDR_W = $bits(udp_pkt_hdr);

endpackage

// File: rtl/udp_merger_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module udp_merger_rr_arbiter #(
    parameter int N    = 3,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester overwrites the others.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        cand         = '0;
        for (int i = N; i >= 1; i--) begin
            cand = ID_W'((int'(last_grant) + i) % N);
            if (req[cand]) begin
                grant_onehot       = '0;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/udp_merger.sv
// Merges N UDP header/data sources onto one TX engine interface.
// Packet-granular round-robin: a grant is held from header accept to last data beat.
module udp_merger
    import udp_merger_pkg::*;
#(
    parameter int UDP_SRCS     = 3,
    parameter int UDP_SRC_ID_W = $clog2(UDP_SRCS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [UDP_SRCS-1:0]                   src_udp_merger_tx_hdr_val,
    input  logic [UDP_SRCS*IP_ADDR_W-1:0]         src_udp_merger_tx_src_ip,
    input  logic [UDP_SRCS*IP_ADDR_W-1:0]         src_udp_merger_tx_dst_ip,
    input  logic [UDP_SRCS*UDP_HDR_W-1:0]         src_udp_merger_tx_udp_hdr,
    input  logic [UDP_SRCS*PKT_TIMESTAMP_W-1:0]   src_udp_merger_tx_timestamp,
    output logic [UDP_SRCS-1:0]                   udp_merger_src_tx_hdr_rdy,
    input  logic [UDP_SRCS-1:0]                   src_udp_merger_tx_data_val,
    input  logic [UDP_SRCS*MAC_INTERFACE_W-1:0]   src_udp_merger_tx_data,
    input  logic [UDP_SRCS-1:0]                   src_udp_merger_tx_last,
    input  logic [UDP_SRCS*MAC_PADBYTES_W-1:0]    src_udp_merger_tx_padbytes,
    output logic [UDP_SRCS-1:0]                   udp_merger_src_tx_data_rdy,
    output logic                                  udp_merger_dst_tx_hdr_val,
    output logic [IP_ADDR_W-1:0]                  udp_merger_dst_tx_src_ip,
    output logic [IP_ADDR_W-1:0]                  udp_merger_dst_tx_dst_ip,
    output logic [UDP_HDR_W-1:0]                  udp_merger_dst_tx_udp_hdr,
    output logic [PKT_TIMESTAMP_W-1:0]            udp_merger_dst_tx_timestamp,
    input  logic                                  dst_udp_merger_tx_hdr_rdy,
    output logic                                  udp_merger_dst_tx_data_val,
    output logic [MAC_INTERFACE_W-1:0]            udp_merger_dst_tx_data,
    output logic                                  udp_merger_dst_tx_last,
    output logic [MAC_PADBYTES_W-1:0]             udp_merger_dst_tx_padbytes,
    input  logic                                  dst_udp_merger_tx_data_rdy
);

    typedef enum logic [1:0] {ARB, HDR, DATA} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [UDP_SRC_ID_W-1:0] grant_reg;
    logic [UDP_SRC_ID_W-1:0] last_grant_reg;
    logic [UDP_SRCS-1:0]     arb_onehot;
    logic [UDP_SRC_ID_W-1:0] arb_idx;
    logic                    arb_any;
    logic                    hdr_fire;
    logic                    data_fire;

    udp_merger_rr_arbiter #(
        .N    (UDP_SRCS),
        .ID_W (UDP_SRC_ID_W)
    ) u_arb (
        .req          (src_udp_merger_tx_hdr_val),
        .last_grant   (last_grant_reg),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    assign arb_any   = |arb_onehot;
    assign hdr_fire  = udp_merger_dst_tx_hdr_val & dst_udp_merger_tx_hdr_rdy;
    assign data_fire = udp_merger_dst_tx_data_val & dst_udp_merger_tx_data_rdy;

    // Payload is a free-running mux; only the val/rdy qualifiers depend on state.
    assign udp_merger_dst_tx_src_ip    = src_udp_merger_tx_src_ip[int'(grant_reg)*IP_ADDR_W +: IP_ADDR_W];
    assign udp_merger_dst_tx_dst_ip    = src_udp_merger_tx_dst_ip[int'(grant_reg)*IP_ADDR_W +: IP_ADDR_W];
    assign udp_merger_dst_tx_udp_hdr   = src_udp_merger_tx_udp_hdr[int'(grant_reg)*UDP_HDR_W +: UDP_HDR_W];
    assign udp_merger_dst_tx_timestamp = src_udp_merger_tx_timestamp[int'(grant_reg)*PKT_TIMESTAMP_W +: PKT_TIMESTAMP_W];
    assign udp_merger_dst_tx_data      = src_udp_merger_tx_data[int'(grant_reg)*MAC_INTERFACE_W +: MAC_INTERFACE_W];
    assign udp_merger_dst_tx_last      = src_udp_merger_tx_last[grant_reg];
    assign udp_merger_dst_tx_padbytes  = src_udp_merger_tx_padbytes[int'(grant_reg)*MAC_PADBYTES_W +: MAC_PADBYTES_W];

    // Reset leaves last_grant at the top index so source 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB;
            grant_reg      <= '0;
            last_grant_reg <= UDP_SRC_ID_W'(UDP_SRCS - 1);
        end else begin
            state <= state_nxt;
            if (state == ARB && arb_any) begin
                grant_reg <= arb_idx;
            end
            if (state == DATA && data_fire && udp_merger_dst_tx_last) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB:     if (arb_any) state_nxt = HDR;
            HDR:     if (hdr_fire) state_nxt = DATA;
            DATA:    if (data_fire && udp_merger_dst_tx_last) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        udp_merger_dst_tx_hdr_val  = 1'b0;
        udp_merger_src_tx_hdr_rdy  = '0;
        udp_merger_dst_tx_data_val = 1'b0;
        udp_merger_src_tx_data_rdy = '0;
        unique case (state)
            HDR: begin
                udp_merger_dst_tx_hdr_val            = src_udp_merger_tx_hdr_val[grant_reg];
                udp_merger_src_tx_hdr_rdy[grant_reg] = dst_udp_merger_tx_hdr_rdy;
            end
            DATA: begin
                udp_merger_dst_tx_data_val            = src_udp_merger_tx_data_val[grant_reg];
                udp_merger_src_tx_data_rdy[grant_reg] = dst_udp_merger_tx_data_rdy;
            end
            default: ;
        endcase
    end

endmodule
